// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between an adder-result producer and the block accumulator.
// master drives results and out_ready; slave returns ready, totals and status.
interface adder_result_accumulator_if #(
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       S;
    logic             Carry;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic [7:0]       count;

    modport master (
        output in_valid, S, Carry, out_ready,
        input  in_ready, out_valid, acc_out, overflow, count
    );

    modport slave (
        input  in_valid, S, Carry, out_ready,
        output in_ready, out_valid, acc_out, overflow, count
    );
endinterface

// File: rtl/adder_result_accumulator.sv
// Sums N_SAMPLES {Carry,S} results per block and holds the total until taken.
// Define ACC_SATURATE_EN to clamp the total at all ones instead of wrapping.
module adder_result_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    adder_result_accumulator_if.slave   bus
);
    // state | meaning
    // IDLE  | waiting for the first result of a block; last total still visible
    // ACCUM | block in progress, more results expected
    // DONE  | total valid on acc_out, inputs blocked until out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] N_LAST = 8'(N_SAMPLES);

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [7:0]       cnt_q;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             last;
    logic [ACC_W-1:0] value;
    logic [ACC_W:0]   sum;

    assign value  = ACC_W'({bus.Carry, bus.S});
    assign sum    = {1'b0, acc_q} + {1'b0, value};
    assign accept = bus.in_valid && in_ready;
    assign last   = (cnt_q + 8'd1) == N_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (N_SAMPLES == 1) ? DONE : ACCUM;
            ACCUM:   if (accept && last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath only moves on an accepted result; DONE and gaps hold everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= 8'd0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                acc_q <= value;
                ovf_q <= 1'b0;
                cnt_q <= 8'd1;
            end else begin
                cnt_q <= cnt_q + 8'd1;
`ifdef ACC_SATURATE_EN
                if (sum[ACC_W]) begin
                    acc_q <= '1;
                    ovf_q <= 1'b1;
                end else begin
                    acc_q <= sum[ACC_W-1:0];
                end
`else
                acc_q <= sum[ACC_W-1:0];
                ovf_q <= ovf_q | sum[ACC_W];
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.acc_out   = acc_q;
    assign bus.overflow  = ovf_q;
    assign bus.count     = cnt_q;
endmodule
